ws2812_frame_sequencer: RTL and testbench

Frame scheduler for the WS2812 LED strip output on `PIN_1`. On a start request, it fetches 24-bit GRB pixel words from a synchronous pixel memory and serializes them MSB-first with WS2812 bit timing, without gaps between pixels. It then holds the line low for the latch interval and reports completion. It sits between the pattern/frame-buffer logic and the top-level `PIN_1` pad. Defaults are for the 16 MHz TinyFPGA clock.

---
 rtl/ws2812_pkg.sv | 37 +++
 rtl/ws2812_frame_sequencer_if.sv | 32 +++
 rtl/ws2812_bit_encoder.sv | 46 ++++
 rtl/ws2812_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Brief    : Shared types and 16 MHz default timing for the WS2812 frame
//            sequencer (FSM state encoding, pixel word width, helpers).
// Revision : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

  // GRB pixel word width
  localparam int c_PIX_W = 24;

  // WS2812 timing at 16 MHz (62.5 ns per cycle)
  localparam int c_BIT_CYCLES   = 20;    // 1.25 us per encoded bit
  localparam int c_T0H_CYCLES   = 6;     // 0.375 us high for a 0 bit
  localparam int c_T1H_CYCLES   = 13;    // 0.8125 us high for a 1 bit
  localparam int c_LATCH_CYCLES = 1120;  // 70 us low to latch the strip

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4
  } ws2812_state_e;

  function automatic int ws2812_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Address width for a pixel memory of n entries, never below one bit
  function automatic int ws2812_addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_sequencer_if
// Brief    : Frame handshake, pixel-memory read port and serial output of
//            the WS2812 frame sequencer. master = sequencer side,
//            slave = frame-buffer / pad side.
// Revision : 1.0 - initial release
// ============================================================================
interface ws2812_frame_sequencer_if
  import ws2812_pkg::*;
#(
  parameter int ADDR_W = 3
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [c_PIX_W-1:0] pix_data;
  logic              led_dout;

  modport master (
    input  start, pix_data,
    output busy, done, pix_rd, pix_addr, led_dout
  );

  modport slave (
    output start, pix_data,
    input  busy, done, pix_rd, pix_addr, led_dout
  );
endinterface
`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_bit_encoder
// Brief    : Turns (bit value, cycle-within-bit) into the registered WS2812
//            line level and a registered end-of-bit strobe. Inputs describe
//            the cycle about to start, so outputs line up with it.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES = c_BIT_CYCLES,
  parameter int T0H_CYCLES = c_T0H_CYCLES,
  parameter int T1H_CYCLES = c_T1H_CYCLES,
  parameter int CNT_W      = 11
) (
  input  wire             CLK,
  input  wire             RST,
  input  wire             en_i,
  input  wire             bit_i,
  input  wire [CNT_W-1:0] cyc_i,
  output logic            dout_o,
  output logic            eob_o
);
  localparam logic [CNT_W-1:0] c_T0H      = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] c_T1H      = CNT_W'(T1H_CYCLES);
  localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic dout_q;
  logic eob_q;

  // High for the first T0H/T1H cycles of the bit, low otherwise; strobe on the last cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= 1'b0;
      eob_q  <= 1'b0;
    end else begin
      dout_q <= en_i && (cyc_i < (bit_i ? c_T1H : c_T0H));
      eob_q  <= en_i && (cyc_i == c_BIT_LAST);
    end
  end

  assign dout_o = dout_q;
  assign eob_o  = eob_q;
endmodule
`default_nettype wire

// File: rtl/ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_frame_sequencer
// Brief    : Fetches GRB pixels from a synchronous pixel memory and streams
//            them back-to-back as WS2812 bits, then holds the latch low time
//            and pulses done. Next pixel is prefetched during bit 0 of the
//            current one. All outputs are registered from next-state values.
// Config   : define WS2812_AUTO_REFRESH_EN to restart a frame directly after
//            each latch (start only needed once after reset).
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BIT_CYCLES   = c_BIT_CYCLES,
  parameter int T0H_CYCLES   = c_T0H_CYCLES,
  parameter int T1H_CYCLES   = c_T1H_CYCLES,
  parameter int LATCH_CYCLES = c_LATCH_CYCLES
) (
  input  wire                      CLK,
  input  wire                      RST,
  ws2812_frame_sequencer_if.master bus
);
  localparam int ADDR_W = ws2812_addr_w(NUM_LEDS);
  localparam int CNT_W  = $clog2(ws2812_max(BIT_CYCLES, LATCH_CYCLES));

  localparam logic [ADDR_W-1:0] c_LAST_PIX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  c_CYC_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  c_LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [4:0]        c_LAST_BIT   = 5'd23;

`ifdef WS2812_AUTO_REFRESH_EN
  localparam bit c_AUTO_REFRESH = 1'b1;
`else
  localparam bit c_AUTO_REFRESH = 1'b0;
`endif

  // Reject timing that cannot be encoded
  if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
        BIT_CYCLES >= 4 && NUM_LEDS >= 1)) begin : g_bad_params
    $error("ws2812_frame_sequencer: need T0H < T1H < BIT_CYCLES, BIT_CYCLES >= 4, NUM_LEDS >= 1");
  end

  ws2812_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [4:0]         bit_q, bit_d;
  logic [ADDR_W-1:0]  pix_q, pix_d;
  logic [c_PIX_W-1:0] shreg_q, shreg_d;
  logic [c_PIX_W-1:0] next_q, next_d;
  logic               pix_rd_q, pix_rd_d;
  logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_dly_q;

  logic               w_eob;
  logic               w_led;

  // State, counters, datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      pix_q      <= '0;
      shreg_q    <= '0;
      next_q     <= '0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_dly_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      pix_q      <= pix_d;
      shreg_q    <= shreg_d;
      next_q     <= next_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_dly_q   <= pix_rd_q;
    end
  end

  // Next-state decode; outputs are derived from the next state so they register in step
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    pix_d      = pix_q;
    shreg_d    = shreg_q;
    next_d     = next_q;
    pix_rd_d   = 1'b0;
    pix_addr_d = pix_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = bus.pix_data;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Prefetched word arrives one cycle after its read strobe
        if (rd_dly_q) next_d = bus.pix_data;
        if (w_eob) begin
          cyc_d = '0;
          if (bit_q == c_LAST_BIT) begin
            if (pix_q == c_LAST_PIX) begin
              state_d = S_LATCH;
            end else begin
              shreg_d = next_q;
              bit_d   = '0;
              pix_d   = pix_q + c_ADDR_ONE;
            end
          end else begin
            // Rotate; wrapped bits are never transmitted
            shreg_d = {shreg_q[c_PIX_W-2:0], shreg_q[c_PIX_W-1]};
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + c_CYC_ONE;
        end
      end
      S_LATCH: begin
        if (cyc_q == c_LATCH_LAST) begin
          cyc_d   = '0;
          state_d = c_AUTO_REFRESH ? S_FETCH : S_IDLE;
        end else begin
          cyc_d = cyc_q + c_CYC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // First read of a frame always targets pixel 0
    if (state_d == S_FETCH) begin
      pix_d      = '0;
      pix_rd_d   = 1'b1;
      pix_addr_d = '0;
    end

    // Prefetch the successor in cycle 0 of bit 0 of every pixel but the last
    if (state_d == S_SHIFT && cyc_d == '0 && bit_d == '0 && pix_d != c_LAST_PIX) begin
      pix_rd_d   = 1'b1;
      pix_addr_d = pix_d + c_ADDR_ONE;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_LATCH) && (cyc_d == c_LATCH_LAST);
  end

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .CNT_W      (CNT_W)
  ) u_enc (
    .CLK    (CLK),
    .RST    (RST),
    .en_i   (state_d == S_SHIFT),
    .bit_i  (shreg_d[c_PIX_W-1]),
    .cyc_i  (cyc_d),
    .dout_o (w_led),
    .eob_o  (w_eob)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pix_rd   = pix_rd_q;
  assign bus.pix_addr = pix_addr_q;
  assign bus.led_dout = w_led;
endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_frame_sequencer
// Brief    : Directed self-checking bench: pixel reads, bit decode, latch and
//            handshake timing, ignored start, mid-frame reset, back-to-back
//            frames; auto-refresh period when WS2812_AUTO_REFRESH_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_sequencer;
`ifdef WS2812_AUTO_REFRESH_EN
  localparam int TB_NUM_LEDS = 8;
`else
  localparam int TB_NUM_LEDS = 2;
`endif
  localparam int TB_ADDR_W = (TB_NUM_LEDS > 1) ? $clog2(TB_NUM_LEDS) : 1;
  localparam int TB_BIT    = 20;
  localparam int TB_T0H    = 6;
  localparam int TB_T1H    = 13;
  localparam int TB_LATCH  = 1120;
  localparam int TB_BUDGET = 6000;

  logic clk;
  logic rst;
  logic [23:0] mem [TB_NUM_LEDS];

  int n_checks = 0;
  int n_errors = 0;

  // Per-frame observations
  int rd_n, first_rd, first_rise, done_at, busy_low, width_bad, period_bad, last_high, bit_n;
  int rd_addr [4];
  logic [47:0] bits_got;

  ws2812_frame_sequencer_if #(.ADDR_W(TB_ADDR_W)) bus ();

  ws2812_frame_sequencer #(
    .NUM_LEDS     (TB_NUM_LEDS),
    .BIT_CYCLES   (TB_BIT),
    .T0H_CYCLES   (TB_T0H),
    .T1H_CYCLES   (TB_T1H),
    .LATCH_CYCLES (TB_LATCH)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel memory: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (bus.pix_rd) bus.pix_data <= mem[bus.pix_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start and observe one frame until done (bounded)
  task automatic run_frame(input bit hold_start, input int poke_at);
    int prev_led, hi_len, last_rise;
    rd_n = 0; first_rd = -1; first_rise = -1; done_at = -1; busy_low = 0;
    width_bad = 0; period_bad = 0; last_high = -1; bit_n = 0; bits_got = '0;
    prev_led = 0; hi_len = 0; last_rise = -1;
    bus.start = 1'b1;
    for (int c = 0; c < TB_BUDGET && done_at < 0; c++) begin
      tick();
      bus.start = hold_start || (c + 1 == poke_at);
      if (bus.pix_rd) begin
        if (rd_n == 0) first_rd = c;
        if (rd_n < 4) rd_addr[rd_n] = int'(bus.pix_addr);
        rd_n++;
      end
      if (!bus.busy) busy_low++;
      if (bus.led_dout) begin
        last_high = c;
        if (prev_led == 0) begin
          if (first_rise < 0) first_rise = c;
          else if (c - last_rise != TB_BIT) period_bad++;
          last_rise = c;
          hi_len = 0;
        end
        hi_len++;
      end else if (prev_led != 0) begin
        bits_got = {bits_got[46:0], (hi_len == TB_T1H)};
        bit_n++;
        if (hi_len != TB_T1H && hi_len != TB_T0H) width_bad++;
      end
      prev_led = int'(bus.led_dout);
      if (bus.done) done_at = c;
    end
    check("frame_done_seen", (done_at >= 0), 1);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    int seen;
`ifdef WS2812_AUTO_REFRESH_EN
    int done_cyc [3];
    int done_n;
`endif
    for (int i = 0; i < TB_NUM_LEDS; i++) mem[i] = 24'h000000;
    mem[0] = 24'hFF0000;
    mem[1] = 24'h000001;
    rst = 1'b1;
    bus.start = 1'b1;   // reset must win over start
    bus.pix_data = '0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pix_rd", bus.pix_rd, 0);
    check("rst_pix_addr", bus.pix_addr, 0);
    check("rst_led", bus.led_dout, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (2) tick();

`ifdef WS2812_AUTO_REFRESH_EN
    // One start, three frames; FETCH+LOAD add two cycles between frames
    done_n = 0; busy_low = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 20000 && done_n < 3; c++) begin
      tick();
      bus.start = 1'b0;
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        done_cyc[done_n] = c;
        done_n++;
      end
    end
    check("auto_done_count", done_n, 3);
    if (done_n == 3) begin
      check("auto_first_done", done_cyc[0], 2 + 4960 - 1);
      check("auto_period_1", done_cyc[1] - done_cyc[0], 4960 + 2);
      check("auto_period_2", done_cyc[2] - done_cyc[1], 4960 + 2);
    end
    check("auto_busy_low", busy_low, 0);
`else
    // Frame 1: reads, decode, timing
    run_frame(1'b0, 0);
    check("f1_rd_count", rd_n, 2);
    check("f1_rd_addr0", rd_addr[0], 0);
    check("f1_rd_addr1", rd_addr[1], 1);
    check("f1_first_rd", first_rd, 0);
    check("f1_rise_latency", first_rise, 2);
    check("f1_bit_count", bit_n, 48);
    check("f1_bits", bits_got, 48'hFF0000_000001);
    check("f1_width_bad", width_bad, 0);
    check("f1_period_bad", period_bad, 0);
    check("f1_busy_low", busy_low, 0);
    check("f1_frame_len", done_at - first_rise + 1, 960 + 1120);
    check("f1_latch_low", done_at - last_high, (TB_BIT - TB_T1H) + TB_LATCH);
    tick();
    check("f1_busy_fall", bus.busy, 0);
    check("f1_done_clear", bus.done, 0);
    extra = 0;
    repeat (5) begin
      tick();
      if (bus.done) extra++;
    end
    check("f1_done_once", extra, 0);

    // Start pulsed mid-SHIFT is ignored
    run_frame(1'b0, 300);
    check("ign_rd_count", rd_n, 2);
    check("ign_frame_len", done_at - first_rise + 1, 960 + 1120);
    check("ign_bits", bits_got, 48'hFF0000_000001);
    repeat (3) tick();

    // Reset at bit 10 (cycle 2) of pixel 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (bus.led_dout) seen = 1;
    end
    check("mr_rise_seen", seen, 1);
    repeat (10 * TB_BIT + 2) tick();
    check("mr_pre_led", bus.led_dout, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_led", bus.led_dout, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_pix_rd", bus.pix_rd, 0);
    repeat (10) tick();
    check("mr_idle_busy", bus.busy, 0);
    run_frame(1'b0, 0);
    check("mr_refetch_addr0", rd_addr[0], 0);
    check("mr_refetch_rd_count", rd_n, 2);
    check("mr_first_rd", first_rd, 0);
    repeat (3) tick();

    // Start held: next frame accepted in the cycle busy is low
    run_frame(1'b1, 0);
    tick();
    check("b2b_busy_low", bus.busy, 0);
    check("b2b_no_rd_yet", bus.pix_rd, 0);
    tick();
    bus.start = 1'b0;
    check("b2b_rd", bus.pix_rd, 1);
    check("b2b_rd_addr", bus.pix_addr, 0);
    check("b2b_busy_high", bus.busy, 1);
    seen = 0;
    for (int c = 0; c < TB_BUDGET && seen == 0; c++) begin
      tick();
      if (bus.done) seen = 1;
    end
    check("b2b_second_done", seen, 1);
    tick();
    check("b2b_end_busy", bus.busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
